// File: rtl/bias_relu_requant_pkg.sv
// Shared layer constants, BRAM region map and FSM encoding for the conv/post-process pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bias_relu_requant_pkg;

    // Layer dimensions
    localparam int CFG_N           = 2;    // input channels
    localparam int CFG_M           = 2;    // output channels
    localparam int CFG_K           = 3;    // kernel size
    localparam int CFG_IFM_R       = 15;
    localparam int CFG_IFM_C       = 15;
    localparam int CFG_OFM_R       = 13;
    localparam int CFG_OFM_C       = 13;
    localparam int CFG_BYTE_OFFSET = 4;    // bytes per 32-bit word

    // Region base addresses (bytes), laid out back to back
    localparam int CFG_IFM_ADDR_START  = 0;
    localparam int CFG_WGT_ADDR_START  = CFG_IFM_ADDR_START + CFG_IFM_R*CFG_IFM_C*CFG_N*CFG_BYTE_OFFSET;
    localparam int CFG_OFM_ADDR_START  = CFG_WGT_ADDR_START + CFG_K*CFG_K*CFG_N*CFG_M*CFG_BYTE_OFFSET;
    localparam int CFG_BIAS_ADDR_START = CFG_OFM_ADDR_START + CFG_M*CFG_OFM_R*CFG_OFM_C*CFG_BYTE_OFFSET;
    localparam int CFG_DST_ADDR_START  = CFG_BIAS_ADDR_START + CFG_M*CFG_BYTE_OFFSET;

    // Requantisation
    localparam int CFG_SHIFT     = 8;
    localparam int CFG_CLAMP_MAX = 255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        B_WAIT = 3'd1,
        B_CAP  = 3'd2,
        P_WAIT = 3'd3,
        P_CAP  = 3'd4,
        P_WR   = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Byte address of word 'idx' inside a region starting at 'base'
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + idx * 32'(CFG_BYTE_OFFSET);
    endfunction

endpackage

// File: rtl/bias_relu_requant_relu.sv
// Combinational requantiser: y = clamp((x + b) >>> SHIFT, 0, CLAMP_MAX), 33-bit sum so no wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module relu_requant
    import bias_relu_requant_pkg::*;
#(
    parameter int SHIFT     = CFG_SHIFT,
    parameter int CLAMP_MAX = CFG_CLAMP_MAX
) (
    input  logic [31:0] i_x,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);

    localparam logic signed [32:0] LP_MAX = 33'(CLAMP_MAX);

    logic signed [32:0] w_s;
    logic signed [32:0] w_t;

    assign w_s = $signed({i_x[31], i_x}) + $signed({i_b[31], i_b});
    assign w_t = w_s >>> SHIFT;

    // Clamp the rescaled sum into the activation range
    always_comb begin
        o_y = 32'd0;
        if (w_t[32]) begin
            o_y = 32'd0;
        end else if (w_t > LP_MAX) begin
            o_y = 32'(CLAMP_MAX);
        end else begin
            o_y = w_t[31:0];
        end
    end

endmodule

// File: rtl/bias_relu_requant.sv
// Walks every oFM word per channel, adds the channel bias, requantises and writes to the dst region.
// Latency: M*(2 + 3*OFM_R*OFM_C) cycles from start sample to first DONE cycle.
// Backpressure: none; fixed BRAM schedule, start is ignored while busy and must drop to re-arm.
module bias_relu_requant
    import bias_relu_requant_pkg::*;
#(
    parameter int M               = CFG_M,
    parameter int OFM_R           = CFG_OFM_R,
    parameter int OFM_C           = CFG_OFM_C,
    parameter int OFM_ADDR_START  = CFG_OFM_ADDR_START,
    parameter int BIAS_ADDR_START = OFM_ADDR_START + M*OFM_R*OFM_C*CFG_BYTE_OFFSET,
    parameter int DST_ADDR_START  = BIAS_ADDR_START + M*CFG_BYTE_OFFSET,
    parameter int SHIFT           = CFG_SHIFT,
    parameter int CLAMP_MAX       = CFG_CLAMP_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ps_control,
    output logic [31:0] pl_status,
    output logic [31:0] BRAM_addr,
    input  logic [31:0] BRAM_rddata,
    output logic [31:0] BRAM_wrdata,
    output logic [3:0]  BRAM_we
);

    localparam int CW  = 16;
    localparam int PIX = OFM_R * OFM_C;
    localparam logic [CW-1:0] LP_C_LAST = CW'(OFM_C - 1);
    localparam logic [CW-1:0] LP_R_LAST = CW'(OFM_R - 1);
    localparam logic [CW-1:0] LP_M_LAST = CW'(M - 1);

    state_t        r_state;
    logic [CW-1:0] r_m;
    logic [CW-1:0] r_r;
    logic [CW-1:0] r_c;
    logic [31:0]   r_bias;

    logic [31:0]   w_idx;
    logic [31:0]   w_y;
    logic          w_last_pix;
    logic          w_unused_ctl;

    // Only bit0 of the control word carries meaning
    assign w_unused_ctl = ^ps_control[31:1];

    // Flat word index of the current pixel; the same index addresses oFM and dst
    assign w_idx      = 32'(r_m) * 32'(PIX) + 32'(r_r) * 32'(OFM_C) + 32'(r_c);
    assign w_last_pix = (r_c == LP_C_LAST) && (r_r == LP_R_LAST);

    relu_requant #(
        .SHIFT     (SHIFT),
        .CLAMP_MAX (CLAMP_MAX)
    ) u_relu_requant (
        .i_x (BRAM_rddata),
        .i_b (r_bias),
        .o_y (w_y)
    );

    // Sequencer: bias fetch per channel, then read/compute/write per pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_m         <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_bias      <= '0;
            BRAM_addr   <= '0;
            BRAM_wrdata <= '0;
            BRAM_we     <= '0;
            pl_status   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    pl_status <= 32'h0;
                    if (ps_control[0]) begin
                        BRAM_addr <= word_addr(32'(BIAS_ADDR_START), 32'd0);
                        pl_status <= 32'h2;
                        r_state   <= B_WAIT;
                    end
                end
                B_WAIT: r_state <= B_CAP;
                B_CAP: begin
                    r_bias    <= BRAM_rddata;
                    BRAM_addr <= word_addr(32'(OFM_ADDR_START), w_idx);
                    r_state   <= P_WAIT;
                end
                P_WAIT: r_state <= P_CAP;
                P_CAP: begin
                    BRAM_wrdata <= w_y;
                    BRAM_addr   <= word_addr(32'(DST_ADDR_START), w_idx);
                    BRAM_we     <= 4'hF;
                    r_state     <= P_WR;
                end
                P_WR: begin
                    BRAM_we <= 4'h0;
                    if (!w_last_pix) begin
                        // Row-major walk: the next pixel is always the next word
                        if (r_c == LP_C_LAST) begin
                            r_c <= '0;
                            r_r <= r_r + 1'b1;
                        end else begin
                            r_c <= r_c + 1'b1;
                        end
                        BRAM_addr <= word_addr(32'(OFM_ADDR_START), w_idx + 32'd1);
                        r_state   <= P_WAIT;
                    end else if (r_m != LP_M_LAST) begin
                        r_r       <= '0;
                        r_c       <= '0;
                        r_m       <= r_m + 1'b1;
                        BRAM_addr <= word_addr(32'(BIAS_ADDR_START), 32'(r_m) + 32'd1);
                        r_state   <= B_WAIT;
                    end else begin
                        pl_status <= 32'h1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    // Held start must not retrigger; wait for it to drop
                    if (!ps_control[0]) begin
                        r_m       <= '0;
                        r_r       <= '0;
                        r_c       <= '0;
                        pl_status <= 32'h0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bias_relu_requant.sv
module tb_bias_relu_requant;
    import bias_relu_requant_pkg::*;

    localparam int B_OFM  = 1944;
    localparam int B_BIAS = 3296;
    localparam int B_DST  = 3304;
    localparam int PIX    = 169;
    localparam int NWR    = 338;
    localparam int LAT    = 1018;
    localparam int S_OFM  = 1944;
    localparam int S_BIAS = 1948;
    localparam int S_DST  = 1952;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [31:0] b_ctl, b_status, b_addr, b_rd, b_wr;
    logic [3:0]  b_we;
    logic [31:0] s_ctl, s_status, s_addr, s_rd, s_wr;
    logic [3:0]  s_we;

    bias_relu_requant u_big (
        .clk(clk), .reset(reset), .ps_control(b_ctl), .pl_status(b_status),
        .BRAM_addr(b_addr), .BRAM_rddata(b_rd), .BRAM_wrdata(b_wr), .BRAM_we(b_we)
    );

    bias_relu_requant #(.M(1), .OFM_R(1), .OFM_C(1)) u_small (
        .clk(clk), .reset(reset), .ps_control(s_ctl), .pl_status(s_status),
        .BRAM_addr(s_addr), .BRAM_rddata(s_rd), .BRAM_wrdata(s_wr), .BRAM_we(s_we)
    );

    // BRAM models: source regions loaded by the test, dst written only by the DUT
    logic [31:0] b_src [0:2047];
    logic [31:0] b_dst [0:2047];
    logic [31:0] s_src [0:2047];
    logic [31:0] s_dst [0:2047];
    int b_wr_cnt = 0;
    int s_wr_cnt = 0;
    int viol = 0;
    logic prev_we = 1'b0;

    always @(posedge clk) begin
        if (b_we == 4'hF) begin
            b_dst[b_addr[12:2]] <= b_wr;
            b_wr_cnt <= b_wr_cnt + 1;
        end
        b_rd <= (b_addr >= B_DST) ? b_dst[b_addr[12:2]] : b_src[b_addr[12:2]];
    end

    always @(posedge clk) begin
        if (s_we == 4'hF) begin
            s_dst[s_addr[12:2]] <= s_wr;
            s_wr_cnt <= s_wr_cnt + 1;
        end
        s_rd <= (s_addr >= S_DST) ? s_dst[s_addr[12:2]] : s_src[s_addr[12:2]];
    end

    function automatic bit bus_bad(input logic [31:0] a, input logic [3:0] we,
                                   input logic busy, input logic pwe);
        bit bad = 1'b0;
        if (we != 4'h0) begin
            if (we != 4'hF) bad = 1'b1;
            if (a < B_DST || a >= B_DST + 4*NWR) bad = 1'b1;
            if (pwe) bad = 1'b1;
        end else if (busy) begin
            if (a < B_OFM || a >= B_BIAS + 8) bad = 1'b1;
        end
        return bad;
    endfunction

    // Address/strobe watchdog on the full-size instance
    always @(negedge clk) begin
        viol    <= viol + (bus_bad(b_addr, b_we, b_status[1], prev_we) ? 1 : 0);
        prev_we <= (b_we != 4'h0);
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic [31:0] ofm;
        logic [31:0] bias;
        logic [31:0] y;
    } vec_t;

    task automatic run_small(output int cyc);
        s_ctl = 32'h1;
        @(posedge clk); #1;
        cyc = 0;
        while (!s_status[0] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_big(input bit disturb, output int cyc);
        b_ctl = 32'h1;
        @(posedge clk); #1;
        cyc = 0;
        while (!b_status[0] && cyc < 3000) begin
            if (disturb) b_ctl = $urandom();
            @(posedge clk); #1;
            cyc++;
        end
        b_ctl = 32'h1;
    endtask

    task automatic load_layer(input logic [31:0] bias0, input logic [31:0] bias1);
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < PIX; i++)
                b_src[B_OFM/4 + m*PIX + i] = 32'(i * 256);
        b_src[B_BIAS/4]     = bias0;
        b_src[B_BIAS/4 + 1] = bias1;
    endtask

    task automatic check_layer(input string tag, input int off0, input int off1);
        int nbad = 0;
        int e;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < PIX; i++) begin
                e = i + ((m == 0) ? off0 : off1);
                if (e > 255) e = 255;
                if (b_dst[B_DST/4 + m*PIX + i] !== 32'(e)) nbad++;
            end
        check({tag, "_bad_words"}, 32'(nbad), 32'd0);
    endtask

    vec_t vt [12];
    int cyc;
    int w0;
    int v0;
    int k;

    initial begin
        vt[0]  = '{32'd2560,       32'd256,        32'd11};
        vt[1]  = '{-32'sd1000,     32'd0,          32'd0};
        vt[2]  = '{32'd100000,     32'd0,          32'd255};
        vt[3]  = '{32'h7FFFFFFF,   32'd1,          32'd255};
        vt[4]  = '{32'hFFFFFFFF,   32'd0,          32'd0};
        vt[5]  = '{32'd65535,      32'd0,          32'd255};
        vt[6]  = '{32'd65279,      32'd0,          32'd254};
        vt[7]  = '{-32'sd256,      32'd512,        32'd1};
        vt[8]  = '{32'h80000000,   32'h80000000,   32'd0};
        vt[9]  = '{32'd255,        32'd0,          32'd0};
        vt[10] = '{32'd256,        32'hFFFFFFFF,   32'd0};
        vt[11] = '{32'd511,        32'd1,          32'd2};

        reset = 1'b1;
        b_ctl = 32'h0;
        s_ctl = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_status", b_status, 32'h0);
        check("rst_addr",   b_addr,   32'h0);
        check("rst_wrdata", b_wr,     32'h0);
        check("rst_we",     32'(b_we), 32'h0);
        check("rst_small_status", s_status, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single-point arithmetic on the 1x1x1 instance
        for (int t = 0; t < 12; t++) begin
            s_src[S_OFM/4]  = vt[t].ofm;
            s_src[S_BIAS/4] = vt[t].bias;
            w0 = s_wr_cnt;
            run_small(cyc);
            check($sformatf("small%0d_latency", t), 32'(cyc), 32'd5);
            check($sformatf("small%0d_y", t), s_dst[S_DST/4], vt[t].y);
            check($sformatf("small%0d_writes", t), 32'(s_wr_cnt - w0), 32'd1);
            s_ctl = 32'h0;
            @(posedge clk); #1;
            check($sformatf("small%0d_idle", t), s_status, 32'h0);
        end

        // Full default layer
        load_layer(32'd0, 32'd512);
        w0 = b_wr_cnt;
        v0 = viol;
        run_big(1'b0, cyc);
        check("run1_latency", 32'(cyc), 32'(LAT));
        check("run1_writes", 32'(b_wr_cnt - w0), 32'(NWR));
        check_layer("run1", 0, 2);
        check("run1_dst0_5",   b_dst[B_DST/4 + 5],         32'd5);
        check("run1_dst1_168", b_dst[B_DST/4 + PIX + 168], 32'd170);
        check("run1_bus", 32'(viol - v0), 32'd0);

        // Start held high through DONE: no second run
        w0 = b_wr_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("held_status", b_status, 32'h1);
        check("held_writes", 32'(b_wr_cnt - w0), 32'd0);
        b_ctl = 32'h0;
        @(posedge clk); #1;
        check("drop_status", b_status, 32'h0);

        // Re-raise start: identical second run
        w0 = b_wr_cnt;
        run_big(1'b0, cyc);
        check("run2_latency", 32'(cyc), 32'(LAT));
        check("run2_writes", 32'(b_wr_cnt - w0), 32'(NWR));
        check_layer("run2", 0, 2);
        b_ctl = 32'h0;
        @(posedge clk); @(posedge clk); #1;

        // Abort with reset while pixel 50 is in P_CAP
        w0 = b_wr_cnt;
        b_ctl = 32'h1;
        k = 0;
        while ((b_wr_cnt - w0) < 50 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check("abort_reach50", 32'(b_wr_cnt - w0), 32'd50);
        @(posedge clk); #1;       // P_CAP of pixel 50
        reset = 1'b1;
        b_ctl = 32'h0;
        @(posedge clk); #1;
        check("abort_we",     32'(b_we), 32'h0);
        check("abort_status", b_status, 32'h0);
        check("abort_state",  32'(u_big.r_state), 32'(IDLE));
        check("abort_writes", 32'(b_wr_cnt - w0), 32'd50);
        reset = 1'b0;
        @(posedge clk); #1;
        load_layer(32'd256, 32'd768);
        w0 = b_wr_cnt;
        run_big(1'b0, cyc);
        check("run3_latency", 32'(cyc), 32'(LAT));
        check("run3_writes", 32'(b_wr_cnt - w0), 32'(NWR));
        check_layer("run3", 1, 3);
        b_ctl = 32'h0;
        @(posedge clk); @(posedge clk); #1;

        // Control word scrambled while busy
        load_layer(32'd1024, 32'd51200);
        w0 = b_wr_cnt;
        run_big(1'b1, cyc);
        check("run4_latency", 32'(cyc), 32'(LAT));
        check("run4_writes", 32'(b_wr_cnt - w0), 32'(NWR));
        check_layer("run4", 4, 200);
        check("run4_dst1_54", b_dst[B_DST/4 + PIX + 54], 32'd254);
        check("run4_dst1_55", b_dst[B_DST/4 + PIX + 55], 32'd255);
        b_ctl = 32'h0;
        @(posedge clk); @(posedge clk); #1;

        check("bus_total", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
